// File: rtl/osd_cmd_pkg.sv
// Shared constants, encodings and helpers for the OSD command-bus initiator.
package osd_cmd_pkg;

  localparam logic [7:0]  OSD_CMD_DISABLE  = 8'h40;
  localparam logic [7:0]  OSD_CMD_ENABLE   = 8'h41;
  localparam int unsigned OSD_CMD_INFO_BIT = 2;
  localparam logic [7:0]  OSD_CMD_WRITE    = 8'h20;

  localparam logic [1:0] OP_DISABLE  = 2'd0;
  localparam logic [1:0] OP_ENABLE   = 2'd1;
  localparam logic [1:0] OP_WRITE    = 2'd2;
  localparam logic [1:0] OP_RESERVED = 2'd3;

  localparam int unsigned OSD_BLOCK_BYTES = 256;
  localparam int unsigned OSD_INFO_PARAMS = 5;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_PARAM, S_DATA, S_GAP} state_t;
  typedef enum logic [1:0] {PHY_IDLE, PHY_LO, PHY_HI} phy_state_t;

  // Width of a down-counter able to hold the largest of the three phase lengths.
  function automatic int unsigned phase_w(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return 32'($clog2(m)) + 32'd1;
  endfunction

  // Command word for a request; the reserved opcode behaves as disable.
  function automatic logic [15:0] cmd_word(input logic [1:0] op, input logic info,
                                           input logic [4:0] block);
    logic [7:0] c;
    c = OSD_CMD_DISABLE;
    case (op)
      OP_ENABLE:               c = OSD_CMD_ENABLE | (8'(info) << OSD_CMD_INFO_BIT);
      OP_WRITE:                c = OSD_CMD_WRITE | {3'b000, block};
      OP_DISABLE, OP_RESERVED: c = OSD_CMD_DISABLE;
    endcase
    return {8'h00, c};
  endfunction

endpackage

// File: rtl/osd_tx_phy.sv
// Word timer: holds io_din stable through a low phase then a high phase of io_strobe.
module osd_tx_phy
  import osd_cmd_pkg::*;
#(
  parameter int unsigned STB_LO = 2,
  parameter int unsigned STB_HI = 2,
  parameter int unsigned CW     = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] word,
  output logic        ack_c,
  output logic        word_done_c,
  output logic        io_strobe,
  output logic [15:0] io_din
);

  localparam logic [CW-1:0] LO_INIT = CW'(STB_LO - 1);
  localparam logic [CW-1:0] HI_INIT = CW'(STB_HI - 1);

  phy_state_t    st;
  logic [CW-1:0] cnt;

  // A new word may be taken while idle or on the edge that ends the current high phase.
  assign word_done_c = (st == PHY_HI) && (cnt == '0);
  assign ack_c       = (st == PHY_IDLE) || word_done_c;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st        <= PHY_IDLE;
      cnt       <= '0;
      io_strobe <= 1'b0;
      io_din    <= '0;
    end else begin
      case (st)
        PHY_LO: begin
          if (cnt == '0) begin
            io_strobe <= 1'b1;
            cnt       <= HI_INIT;
            st        <= PHY_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PHY_HI: begin
          if (cnt == '0) begin
            io_strobe <= 1'b0;
            st        <= PHY_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
      if (load && ack_c) begin
        io_din <= word;
        cnt    <= LO_INIT;
        st     <= PHY_LO;
      end
    end
  end

endmodule

// File: rtl/osd_cmd_tx.sv
// OSD command-bus initiator: turns one request into a framed command/parameter/data burst.
module osd_cmd_tx
  import osd_cmd_pkg::*;
#(
  parameter int unsigned STB_LO = 2,
  parameter int unsigned STB_HI = 2,
  parameter int unsigned GAP    = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_info,
  input  logic [11:0] req_infox,
  input  logic [11:0] req_infoy,
  input  logic [5:0]  req_infow,
  input  logic [5:0]  req_infoh,
  input  logic [1:0]  req_rot,
  input  logic [4:0]  req_block,
  input  logic [8:0]  req_len,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   CW       = phase_w(STB_LO, STB_HI, GAP);
  localparam logic [CW-1:0] GAP_INIT = CW'(GAP - 1);
  localparam logic [8:0]    MAX_LEN  = 9'(OSD_BLOCK_BYTES);

  state_t        state;
  logic [1:0]    op_q;
  logic          info_q;
  logic [11:0]   infox_q, infoy_q;
  logic [5:0]    infow_q, infoh_q;
  logic [1:0]    rot_q;
  logic [8:0]    len_q, wcnt;
  logic [2:0]    pidx;
  logic [CW-1:0] gcnt;

  logic          phy_ack_c, phy_done_c, load_c;
  logic [15:0]   word_c, param_word_c;
  logic          go_param_c, go_data_c, params_left_c;

  assign go_param_c    = (op_q == OP_ENABLE) && info_q;
  assign go_data_c     = (op_q == OP_WRITE) && (len_q != '0);
  assign params_left_c = (pidx != 3'(OSD_INFO_PARAMS));

  always_comb begin
    param_word_c = {14'h0, rot_q};
    case (pidx)
      3'd0:    param_word_c = {4'h0, infox_q};
      3'd1:    param_word_c = {4'h0, infoy_q};
      3'd2:    param_word_c = {10'h0, infow_q};
      3'd3:    param_word_c = {10'h0, infoh_q};
      default: ;
    endcase
  end

  // Next word for the phy; the command word is built from the live request on acceptance.
  always_comb begin
    load_c = 1'b0;
    word_c = '0;
    case (state)
      S_IDLE: begin
        load_c = req_valid;
        word_c = cmd_word(req_op, req_info, req_block);
      end
      S_CMD: begin
        if (phy_done_c && go_param_c) begin
          load_c = 1'b1;
          word_c = param_word_c;
        end else if (phy_done_c && go_data_c) begin
          load_c = s_valid;
          word_c = {8'h00, s_data};
        end
      end
      S_PARAM: begin
        load_c = phy_done_c && params_left_c;
        word_c = param_word_c;
      end
      S_DATA: begin
        load_c = phy_ack_c && (wcnt != len_q) && s_valid;
        word_c = {8'h00, s_data};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      io_osd    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s_ready   <= 1'b0;
      op_q      <= '0;
      info_q    <= 1'b0;
      infox_q   <= '0;
      infoy_q   <= '0;
      infow_q   <= '0;
      infoh_q   <= '0;
      rot_q     <= '0;
      len_q     <= '0;
      wcnt      <= '0;
      pidx      <= '0;
      gcnt      <= '0;
    end else begin
      done    <= 1'b0;
      s_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            info_q    <= req_info;
            infox_q   <= req_infox;
            infoy_q   <= req_infoy;
            infow_q   <= req_infow;
            infoh_q   <= req_infoh;
            rot_q     <= req_rot;
            len_q     <= (req_len > MAX_LEN) ? MAX_LEN : req_len;
            wcnt      <= '0;
            pidx      <= '0;
            io_osd    <= 1'b1;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= S_CMD;
          end
        end
        S_CMD: begin
          if (phy_done_c) begin
            if (go_param_c) begin
              pidx  <= 3'd1;
              state <= S_PARAM;
            end else if (go_data_c) begin
              state <= S_DATA;
              if (s_valid) begin
                s_ready <= 1'b1;
                wcnt    <= 9'd1;
              end
            end else begin
              io_osd <= 1'b0;
              gcnt   <= GAP_INIT;
              state  <= S_GAP;
            end
          end
        end
        S_PARAM: begin
          if (phy_done_c) begin
            if (params_left_c) begin
              pidx <= pidx + 3'd1;
            end else begin
              io_osd <= 1'b0;
              gcnt   <= GAP_INIT;
              state  <= S_GAP;
            end
          end
        end
        S_DATA: begin
          // Once the last byte is loaded the phy only acks again when that word ends.
          if (phy_ack_c) begin
            if (wcnt == len_q) begin
              io_osd <= 1'b0;
              gcnt   <= GAP_INIT;
              state  <= S_GAP;
            end else if (s_valid) begin
              s_ready <= 1'b1;
              wcnt    <= wcnt + 9'd1;
            end
          end
        end
        S_GAP: begin
          if (gcnt == '0) begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            gcnt <= gcnt - 1'b1;
            if (gcnt == CW'(1)) done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  osd_tx_phy #(
    .STB_LO (STB_LO),
    .STB_HI (STB_HI),
    .CW     (CW)
  ) u_phy (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .load        (load_c),
    .word        (word_c),
    .ack_c       (phy_ack_c),
    .word_done_c (phy_done_c),
    .io_strobe   (io_strobe),
    .io_din      (io_din)
  );

endmodule
